// File: rtl/mimc_pkg.sv
// mimc_pkg: shared types, constants and field helpers for the MiMC blocks.
//   fe_t          - one BN254 scalar-field element (254 bits)
//   perm_state_e  - permutation controller states
//   MIMC_N_ROUNDS - round count of the MiMC Feistel permutation
//   BN254_P       - field modulus
//   add_mod       - (a + b) mod p for reduced operands
//   dbl_add_mod   - one double-and-add step of an MSB-first modular multiply
package mimc_pkg;

    localparam int FE_W = 254;

    typedef logic [FE_W-1:0] fe_t;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, RUN, STEP, DONE} perm_state_e;

    localparam int MIMC_N_ROUNDS = 220;

    localparam logic [255:0] BN254_P_256 =
        256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
    localparam fe_t BN254_P = BN254_P_256[FE_W-1:0];

    // Both operands are already reduced, so one conditional subtract suffices.
    function automatic fe_t add_mod(input fe_t a, input fe_t b);
        logic [FE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, BN254_P}) s = s - {1'b0, BN254_P};
        return s[FE_W-1:0];
    endfunction

    // acc' = 2*acc + (bit ? b : 0)  (mod p)
    function automatic fe_t dbl_add_mod(input fe_t acc, input fe_t b, input logic bit_i);
        fe_t t;
        t = add_mod(acc, acc);
        if (bit_i) t = add_mod(t, b);
        return t;
    endfunction

endpackage

// File: rtl/mimc_feistel_perm_ctrl_if.sv
// mimc_feistel_perm_ctrl_if: operand and result streams of the MiMC
// permutation controller.
//   in_valid/in_ready + in_left/in_right/in_key : job request
//   out_valid/out_ready + out_left/out_right    : job result
// master = requester / result consumer, slave = controller.
interface mimc_feistel_perm_ctrl_if #(
    parameter int N_BITS = 254
);
    logic              in_valid;
    logic              in_ready;
    logic [N_BITS-1:0] in_left;
    logic [N_BITS-1:0] in_right;
    logic [N_BITS-1:0] in_key;
    logic              out_valid;
    logic              out_ready;
    logic [N_BITS-1:0] out_left;
    logic [N_BITS-1:0] out_right;

    modport master (
        output in_valid, in_left, in_right, in_key, out_ready,
        input  in_ready, out_valid, out_left, out_right
    );

    modport slave (
        input  in_valid, in_left, in_right, in_key, out_ready,
        output in_ready, out_valid, out_left, out_right
    );
endinterface

// File: rtl/mimc_feistel_cipher_round.sv
// mimc_feistel_cipher_round: one MiMC Feistel round over BN254.
//   t = left + key + rc ; f = t^5 (mod p)
//   normal round: (left, right) -> (right + f, left)
//   last round  : (left, right) -> (left, right + f)
// t^5 is built from three MSB-first double-and-add modular multiplies
// (t*t, t^2*t^2, t^4*t). "peasant" handles 1 multiplier bit per clock;
// any other method string handles 2.
// Ports: clk; rst (sync, active-high, re-arms the round); en (advance);
//   in_left/in_right/rc/key/is_last_round (held stable from the first en
//   cycle until done); done (sticky until rst); out_left/out_right (valid
//   while done=1). done rises after 3*N_BITS/STEP_BITS + 2 enabled edges.
module mimc_feistel_cipher_round
    import mimc_pkg::*;
#(
    parameter int N_BITS             = 254,
    parameter     GALOIS_MULT_METHOD = "peasant"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_BITS-1:0] in_left,
    input  logic [N_BITS-1:0] in_right,
    input  logic [N_BITS-1:0] rc,
    input  logic [N_BITS-1:0] key,
    input  logic              is_last_round,
    output logic              done,
    output logic [N_BITS-1:0] out_left,
    output logic [N_BITS-1:0] out_right
);
    localparam int STEP_BITS  = (GALOIS_MULT_METHOD == "peasant") ? 1 : 2;
    localparam int MULT_STEPS = N_BITS / STEP_BITS;
    localparam int STEP_W     = $clog2(MULT_STEPS);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MULT_STEPS - 1);

    typedef enum logic [2:0] {PH_ADD, PH_SQ, PH_QU, PH_QI, PH_OUT, PH_HOLD} phase_e;

    phase_e            phase;
    logic [STEP_W-1:0] step_q;
    fe_t               t_q, a_sh, b_q, acc_q, acc_next, t_sum;

    assign t_sum = add_mod(add_mod(in_left, key), rc);

    // NOTE: blocking '=' here chains the per-bit steps combinationally;
    // clocked state below is written with '<=' only.
    always_comb begin
        acc_next = acc_q;
        for (int j = 0; j < STEP_BITS; j++)
            acc_next = dbl_add_mod(acc_next, b_q, a_sh[N_BITS-1-j]);
    end

    // NOTE: only the control state (phase, step, done) is reset; the wide
    // operand/result registers are always written before they are consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase  <= PH_ADD;
            step_q <= '0;
            done   <= 1'b0;
        end else if (en) begin
            case (phase)
                PH_ADD: begin
                    t_q    <= t_sum;
                    a_sh   <= t_sum;
                    b_q    <= t_sum;
                    acc_q  <= '0;
                    step_q <= LAST_STEP;
                    phase  <= PH_SQ;
                end
                PH_SQ, PH_QU, PH_QI: begin
                    acc_q  <= acc_next;
                    a_sh   <= a_sh << STEP_BITS;
                    step_q <= step_q - 1'b1;
                    if (step_q == '0) begin
                        step_q <= LAST_STEP;
                        case (phase)
                            PH_SQ: begin
                                a_sh  <= acc_next;
                                b_q   <= acc_next;
                                acc_q <= '0;
                                phase <= PH_QU;
                            end
                            PH_QU: begin
                                a_sh  <= acc_next;
                                b_q   <= t_q;
                                acc_q <= '0;
                                phase <= PH_QI;
                            end
                            default: phase <= PH_OUT;
                        endcase
                    end
                end
                PH_OUT: begin
                    // acc_q now holds t^5
                    if (is_last_round) begin
                        out_left  <= in_left;
                        out_right <= add_mod(in_right, acc_q);
                    end else begin
                        out_left  <= add_mod(in_right, acc_q);
                        out_right <= in_left;
                    end
                    done  <= 1'b1;
                    phase <= PH_HOLD;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/mimc_feistel_perm_ctrl.sv
// mimc_feistel_perm_ctrl: runs one shared mimc_feistel_cipher_round for
// N_ROUNDS rounds to compute a full MiMC Feistel permutation.
// Ports:
//   clk, rst_n    - clock, synchronous active-low reset
//   io (slave)    - in_valid/in_ready/in_left/in_right/in_key request,
//                   out_valid/out_ready/out_left/out_right result
//   rc_addr       - round-constant ROM address (= current round)
//   rc_data       - ROM data, valid one cycle after rc_addr
//   busy          - high from accept until the output handshake
//   perf_cycles   - accept-to-out_valid cycles of last job (saturating)
//   perf_jobs     - completed output handshakes (wrapping)
// perf_* exist only when MIMC_PERM_CTRL_PERF_EN is defined.
// Per round: FETCH, LOAD, RUN (core run time), STEP.
module mimc_feistel_perm_ctrl
    import mimc_pkg::*;
#(
    parameter int N_BITS             = 254,
    parameter int N_ROUNDS           = MIMC_N_ROUNDS,
    parameter     GALOIS_MULT_METHOD = "peasant",
    parameter int RC_ADDR_W          = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    mimc_feistel_perm_ctrl_if.slave  io,
    output logic [RC_ADDR_W-1:0]     rc_addr,
    input  logic [N_BITS-1:0]        rc_data,
    output logic                     busy
`ifdef MIMC_PERM_CTRL_PERF_EN
    ,
    output logic [31:0]              perf_cycles,
    output logic [15:0]              perf_jobs
`endif
);
    localparam logic [RC_ADDR_W-1:0] LAST_RND = RC_ADDR_W'(N_ROUNDS - 1);

    perm_state_e          state_q, state_d;
    logic [RC_ADDR_W-1:0] round_q;
    fe_t                  left_q, right_q, key_q, rc_q;
    fe_t                  core_left, core_right;
    logic                 core_rst, core_en, core_done, is_last, accept;

    assign is_last = (round_q == LAST_RND);
    assign accept  = io.in_valid && io.in_ready;
    assign rc_addr = round_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        io.in_ready  = 1'b0;
        io.out_valid = 1'b0;
        busy         = 1'b1;
        core_rst     = 1'b1;
        core_en      = 1'b0;
        case (state_q)
            IDLE: begin
                busy        = 1'b0;
                io.in_ready = rst_n;   // stays low while reset is asserted
                if (io.in_valid && rst_n) state_d = FETCH;
            end
            FETCH: state_d = LOAD;
            LOAD:  state_d = RUN;
            RUN: begin
                core_rst = !rst_n;
                core_en  = rst_n;
                if (core_done) state_d = STEP;
            end
            STEP: state_d = is_last ? DONE : FETCH;
            DONE: begin
                io.out_valid = 1'b1;
                if (io.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            round_q <= '0;
            left_q  <= '0;
            right_q <= '0;
            key_q   <= '0;
            rc_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    left_q  <= io.in_left;
                    right_q <= io.in_right;
                    key_q   <= io.in_key;
                    round_q <= '0;
                end
                LOAD: rc_q <= rc_data;
                STEP: begin
                    left_q  <= core_left;
                    right_q <= core_right;
                    if (!is_last) round_q <= round_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign io.out_left  = (state_q == DONE) ? left_q  : '0;
    assign io.out_right = (state_q == DONE) ? right_q : '0;

    // Core operands come only from registers that do not change during RUN.
    mimc_feistel_cipher_round #(
        .N_BITS             (N_BITS),
        .GALOIS_MULT_METHOD (GALOIS_MULT_METHOD)
    ) u_round (
        .clk           (clk),
        .rst           (core_rst),
        .en            (core_en),
        .in_left       (left_q),
        .in_right      (right_q),
        .rc            (rc_q),
        .key           (key_q),
        .is_last_round (is_last),
        .done          (core_done),
        .out_left      (core_left),
        .out_right     (core_right)
    );

`ifdef MIMC_PERM_CTRL_PERF_EN
    logic [31:0] run_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_cnt_q   <= '0;
            perf_cycles <= '0;
            perf_jobs   <= '0;
        end else begin
            if (accept)
                run_cnt_q <= 32'd1;
            else if (busy && state_q != DONE && run_cnt_q != '1)
                run_cnt_q <= run_cnt_q + 1'b1;
            if (state_q == STEP && state_d == DONE)
                perf_cycles <= (run_cnt_q == '1) ? '1 : run_cnt_q + 1'b1;
            if (io.out_valid && io.out_ready)
                perf_jobs <= perf_jobs + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mimc_feistel_perm_ctrl.sv
// tb_mimc_feistel_perm_ctrl: self-checking bench for mimc_feistel_perm_ctrl
// with N_ROUNDS=8. A field-arithmetic model (wide multiply and %) predicts
// every result; a negedge monitor compares outputs whenever out_valid is high.
module tb_mimc_feistel_perm_ctrl;
    import mimc_pkg::*;

    localparam int N_ROUNDS    = 8;
    localparam int L_CORE      = 3 * 254 + 3;              // RUN cycles per round
    localparam int JOB_CYC     = N_ROUNDS * (3 + L_CORE) + 1;
    localparam int WAIT_BUDGET = 2 * JOB_CYC;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] rc_addr;
    fe_t        rc_data;
    logic       busy;
`ifdef MIMC_PERM_CTRL_PERF_EN
    logic [31:0] perf_cycles;
    logic [15:0] perf_jobs;
`endif

    mimc_feistel_perm_ctrl_if #(.N_BITS(254)) io ();

    mimc_feistel_perm_ctrl #(
        .N_BITS   (254),
        .N_ROUNDS (N_ROUNDS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .io          (io),
        .rc_addr     (rc_addr),
        .rc_data     (rc_data),
        .busy        (busy)
`ifdef MIMC_PERM_CTRL_PERF_EN
        ,
        .perf_cycles (perf_cycles),
        .perf_jobs   (perf_jobs)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Round-constant ROM: one cycle read latency.
    fe_t rom [N_ROUNDS];
    initial begin
        for (int i = 0; i < N_ROUNDS; i++) rom[i] = BN254_P - fe_t'(1 + i * 1000003);
        rom[0]          = '0;
        rom[N_ROUNDS-1] = '0;
    end
    always @(posedge clk) rc_data <= rom[rc_addr];

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- field model ----------------
    function automatic fe_t fadd(input fe_t a, input fe_t b);
        logic [255:0] s;
        s = 256'(a) + 256'(b);
        return fe_t'(s % 256'(BN254_P));
    endfunction

    function automatic fe_t fmul(input fe_t a, input fe_t b);
        logic [511:0] p;
        p = 512'(a) * 512'(b);
        return fe_t'(p % 512'(BN254_P));
    endfunction

    function automatic fe_t pow5(input fe_t x);
        fe_t x2, x4;
        x2 = fmul(x, x);
        x4 = fmul(x2, x2);
        return fmul(x4, x);
    endfunction

    task automatic model_round(input fe_t l, input fe_t r, input fe_t c, input fe_t k,
                               input bit last, output fe_t ol, output fe_t orr);
        fe_t f;
        f = pow5(fadd(fadd(l, k), c));
        if (last) begin ol = l;          orr = fadd(r, f); end
        else      begin ol = fadd(r, f); orr = l;          end
    endtask

    task automatic model_perm(input fe_t l, input fe_t r, input fe_t k,
                              output fe_t ol, output fe_t orr);
        fe_t cl, cr, nl, nr;
        cl = l;
        cr = r;
        for (int i = 0; i < N_ROUNDS; i++) begin
            model_round(cl, cr, rom[i], k, (i == N_ROUNDS - 1), nl, nr);
            cl = nl;
            cr = nr;
        end
        ol  = cl;
        orr = cr;
    endtask

    // ---------------- monitor / scoreboard ----------------
    fe_t exp_l[$], exp_r[$];
    int  acc_hist[$], hs_hist[$];
    int  acc_cyc = 0;
    int  n_hs    = 0;
    bit  prev_ov = 1'b0;
    fe_t ml, mr;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (io.in_valid && io.in_ready) begin
                model_perm(io.in_left, io.in_right, io.in_key, ml, mr);
                exp_l.push_back(ml);
                exp_r.push_back(mr);
                acc_cyc = cyc;
                acc_hist.push_back(cyc);
            end
            check("busy_vs_in_ready", busy, !io.in_ready);
            if (io.out_valid) begin
                if (!prev_ov) begin
                    check("accept_to_out_valid", cyc - acc_cyc, JOB_CYC);
                    check("rc_addr_at_done", rc_addr, N_ROUNDS - 1);
                end
                if (exp_l.size() == 0) begin
                    check("out_valid_expected", 1'b0, 1'b1);
                end else begin
                    check("out_left", io.out_left, exp_l[0]);
                    check("out_right", io.out_right, exp_r[0]);
                end
                if (io.out_ready) begin
                    if (exp_l.size() != 0) begin
                        void'(exp_l.pop_front());
                        void'(exp_r.pop_front());
                    end
                    hs_hist.push_back(cyc);
                    n_hs++;
                end
            end
            prev_ov = io.out_valid;
        end else begin
            prev_ov = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input fe_t l, input fe_t r, input fe_t k);
        bit ok = 1'b0;
        @(posedge clk); #1;
        io.in_valid = 1'b1;
        io.in_left  = l;
        io.in_right = r;
        io.in_key   = k;
        for (int n = 0; n < WAIT_BUDGET; n++) begin
            @(negedge clk);
            if (io.in_ready) begin ok = 1'b1; break; end
        end
        check("accept_wait", ok, 1'b1);
        @(posedge clk); #1;
        io.in_valid = 1'b0;
    endtask

    task automatic wait_hs(input int target);
        bit ok = 1'b0;
        for (int n = 0; n < WAIT_BUDGET; n++) begin
            @(negedge clk);
            if (n_hs >= target) begin ok = 1'b1; break; end
        end
        check("handshake_wait", ok, 1'b1);
    endtask

    // ---------------- main sequence ----------------
    fe_t pl, pr, pm1;
    bit  seen;

    initial begin
        rst_n        = 1'b0;
        io.in_valid  = 1'b0;
        io.in_left   = '0;
        io.in_right  = '0;
        io.in_key    = '0;
        io.out_ready = 1'b0;

        // Model pins: t = 1+4+3 = 8, 8^5 = 32768.
        model_round(254'd1, 254'd2, 254'd3, 254'd4, 1'b0, pl, pr);
        check("pin_round_mid_left", pl, 32770);
        check("pin_round_mid_right", pr, 1);
        model_round(254'd1, 254'd2, 254'd3, 254'd4, 1'b1, pl, pr);
        check("pin_round_last_left", pl, 1);
        check("pin_round_last_right", pr, 32770);
        pm1 = BN254_P - 254'd1;
        check("pin_pow5_minus_one", pow5(pm1), pm1);
        check("pin_add_wrap", fadd(pm1, 254'd5), 4);

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", io.in_ready, 0);
        check("rst_out_valid", io.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rc_addr", rc_addr, 0);
        check("rst_out_left", io.out_left, 0);
        check("rst_out_right", io.out_right, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", io.in_ready, 1);

        // Job A: all-zero inputs, out_ready already high before DONE.
        io.out_ready = 1'b1;
        send('0, '0, '0);
        wait_hs(1);
`ifdef MIMC_PERM_CTRL_PERF_EN
        check("perf_cycles", perf_cycles, JOB_CYC);
        check("perf_jobs_one", perf_jobs, 1);
`endif

        // Job B: back-pressure for 50 cycles, in_valid pulses ignored.
        io.out_ready = 1'b0;
        send(BN254_P - 254'd1, 254'd12345, 254'd7);
        seen = 1'b0;
        for (int n = 0; n < WAIT_BUDGET; n++) begin
            @(negedge clk);
            if (io.out_valid) begin seen = 1'b1; break; end
        end
        check("out_valid_wait", seen, 1'b1);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            io.in_valid = i[0];
            io.in_left  = fe_t'(i);
            @(negedge clk);
            check("bp_in_ready", io.in_ready, 0);
            check("bp_out_valid", io.out_valid, 1);
        end
        @(posedge clk); #1;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        wait_hs(2);

        // Jobs C and D back to back, D held valid while C runs.
        send(254'd1, 254'd2, 254'd3);
        send(254'h1d2c3b4a59687766554433221100ffeeddccbbaa99887766554433221100,
             254'h0123456789abcdef0123456789abcdef0123456789abcdef0123456789ab,
             254'h00fedcba9876543210fedcba9876543210);
        wait_hs(4);
        check("b2b_accept_cycle", acc_hist[3], hs_hist[2] + 1);

        // Job E aborted by reset during round 7 RUN; job F then runs clean.
        send(254'd5, 254'd6, BN254_P - 254'd2);
        seen = 1'b0;
        for (int n = 0; n < WAIT_BUDGET; n++) begin
            @(negedge clk);
            if (rc_addr == 3'd7) begin seen = 1'b1; break; end
        end
        check("round7_wait", seen, 1'b1);
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_l.delete();
        exp_r.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_in_ready", io.in_ready, 1);
        check("abort_out_valid", io.out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_rc_addr", rc_addr, 0);
        send(254'd777, 254'd888, 254'd999);
        wait_hs(5);
`ifdef MIMC_PERM_CTRL_PERF_EN
        check("perf_jobs_after_abort", perf_jobs, 1);
`endif
        repeat (5) @(negedge clk);
        check("handshake_count", n_hs, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
